// File: rtl/alu_op_sequencer_if.sv
// Command, operation-block and response bundle for alu_op_sequencer.
// slave = sequencer side, master = requesters / operation blocks / consumer side.
interface alu_op_sequencer_if #(
   parameter int NUM_OPS = 4
);
   logic               req0_valid;
   logic               req0_ready;
   logic [1:0]         req0_op;
   logic [3:0]         req0_a;
   logic [3:0]         req0_b;
   logic               req1_valid;
   logic               req1_ready;
   logic [1:0]         req1_op;
   logic [3:0]         req1_a;
   logic [3:0]         req1_b;
   logic [NUM_OPS-1:0] op_enable;
   logic [3:0]         alu_a;
   logic [3:0]         alu_b;
   logic [3:0]         alu_result;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [3:0]         rsp_data;
   logic               busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output op_enable, alu_a, alu_b,
      input  alu_result,
      output rsp_valid, rsp_id, rsp_data, busy,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  op_enable, alu_a, alu_b,
      output alu_result,
      input  rsp_valid, rsp_id, rsp_data, busy,
      output rsp_ready
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Round-robin two-requester sequencer for the 4-bit ALU datapath: grant, drive one op block
// for SETTLE_CYCLES, capture the OR-ed result bus, answer on a valid/ready response channel.
// Optional op_count/conflict_count outputs are built when ALU_OP_SEQUENCER_STATS_EN is defined.
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int NUM_OPS       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_op_sequencer_if.slave bus
`ifdef ALU_OP_SEQUENCER_STATS_EN
   ,
   output logic [7:0]        op_count,
   output logic [7:0]        conflict_count
`endif
);

   if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE_CYCLES must be within 1..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [3:0]         LAST_CNT     = 4'(SETTLE_CYCLES - 1);
   localparam logic [NUM_OPS-1:0] ONE_HOT_BASE = NUM_OPS'(1);

   function automatic logic [NUM_OPS-1:0] op_onehot(input logic [1:0] op);
      op_onehot = ONE_HOT_BASE << op;
   endfunction

   state_t             state_r, state_s;
   logic [3:0]         cnt_r, cnt_s;
   logic [1:0]         op_r, op_s;
   logic [3:0]         a_r, a_s, b_r, b_s;
   logic               id_r, id_s;
   logic               last_grant_r, last_grant_s;
   logic [NUM_OPS-1:0] en_r, en_s;
   logic [3:0]         alu_a_r, alu_a_s, alu_b_r, alu_b_s;
   logic               rsp_valid_r, rsp_valid_s;
   logic [3:0]         rsp_data_r, rsp_data_s;
   logic               rsp_id_r, rsp_id_s;
   logic               busy_r;
   logic               grant_valid_s, grant_id_s;
   logic [1:0]         sel_op_s;
   logic [3:0]         sel_a_s, sel_b_s;

   // Round-robin pick between valid requesters; a grant exists only while idle.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
      if (state_r == ST_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
         end else if (bus.req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
         end else if (bus.req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
         end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
         end
      end else begin
         grant_valid_s = 1'b0;
         grant_id_s    = 1'b0;
      end
   end

   assign sel_op_s       = grant_id_s ? bus.req1_op : bus.req0_op;
   assign sel_a_s        = grant_id_s ? bus.req1_a  : bus.req0_a;
   assign sel_b_s        = grant_id_s ? bus.req1_b  : bus.req0_b;
   assign bus.req0_ready = grant_valid_s & ~grant_id_s;
   assign bus.req1_ready = grant_valid_s &  grant_id_s;

   // Next state plus next values of every registered output; the op bus idles at zero.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      op_s         = op_r;
      a_s          = a_r;
      b_s          = b_r;
      id_s         = id_r;
      last_grant_s = last_grant_r;
      en_s         = '0;
      alu_a_s      = 4'h0;
      alu_b_s      = 4'h0;
      rsp_valid_s  = rsp_valid_r;
      rsp_data_s   = rsp_data_r;
      rsp_id_s     = rsp_id_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_valid_s) begin
               op_s         = sel_op_s;
               a_s          = sel_a_s;
               b_s          = sel_b_s;
               id_s         = grant_id_s;
               last_grant_s = grant_id_s;
               cnt_s        = 4'd0;
               en_s         = op_onehot(sel_op_s);
               alu_a_s      = sel_a_s;
               alu_b_s      = sel_b_s;
               state_s      = ST_DRIVE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            // The bus already carries the settled result during the last drive cycle.
            if (cnt_r == LAST_CNT) begin
               rsp_valid_s = 1'b1;
               rsp_data_s  = bus.alu_result;
               rsp_id_s    = id_r;
               cnt_s       = 4'd0;
               state_s     = ST_RESP;
            end else begin
               cnt_s   = cnt_r + 4'd1;
               en_s    = op_onehot(op_r);
               alu_a_s = a_r;
               alu_b_s = b_r;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            rsp_valid_s = 1'b0;
            cnt_s       = 4'd0;
         end
      endcase
   end

   // State, command latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         op_r         <= 2'd0;
         a_r          <= 4'h0;
         b_r          <= 4'h0;
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
         en_r         <= '0;
         alu_a_r      <= 4'h0;
         alu_b_r      <= 4'h0;
         rsp_valid_r  <= 1'b0;
         rsp_data_r   <= 4'h0;
         rsp_id_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         op_r         <= op_s;
         a_r          <= a_s;
         b_r          <= b_s;
         id_r         <= id_s;
         last_grant_r <= last_grant_s;
         en_r         <= en_s;
         alu_a_r      <= alu_a_s;
         alu_b_r      <= alu_b_s;
         rsp_valid_r  <= rsp_valid_s;
         rsp_data_r   <= rsp_data_s;
         rsp_id_r     <= rsp_id_s;
         busy_r       <= (state_s != ST_IDLE);
      end
   end

   assign bus.op_enable = en_r;
   assign bus.alu_a     = alu_a_r;
   assign bus.alu_b     = alu_b_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.busy      = busy_r;

`ifdef ALU_OP_SEQUENCER_STATS_EN
   logic [7:0] op_count_r;
   logic [7:0] conflict_count_r;

   // Wrapping counters of response handshakes and contended grants.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_r       <= 8'd0;
         conflict_count_r <= 8'd0;
      end else begin
         if ((state_r == ST_RESP) && rsp_valid_r && bus.rsp_ready) begin
            op_count_r <= op_count_r + 8'd1;
         end else begin
            op_count_r <= op_count_r;
         end
         if (grant_valid_s && bus.req0_valid && bus.req1_valid) begin
            conflict_count_r <= conflict_count_r + 8'd1;
         end else begin
            conflict_count_r <= conflict_count_r;
         end
      end
   end

   assign op_count       = op_count_r;
   assign conflict_count = conflict_count_r;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Controller for the 4-bit ALU datapath. Arbitrates between two requesters with round-robin, latches the winner's opcode and operands, and drives the selected operation block's enable with operands for a fixed settle window. It then captures the shared result bus and returns the result over a valid/ready response channel. Operation blocks output zero when disabled, so the result bus is the external OR of all block outputs.

Parameters:
- SETTLE_CYCLES, 1, cycles enable/operands held before capture; legal range 1..15; 0 is illegal (elaboration error).
- NUM_OPS, 4, width of one-hot enable bus; op index 0=AND, 1=OR, 2=XOR, 3=ADD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  2  requester 0 operation index.
- req0_a  input  4  requester 0 operand a.
- req0_b  input  4  requester 0 operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- op_enable  output  NUM_OPS  one-hot enable to operation blocks.
- alu_a  output  4  operand a to operation blocks.
- alu_b  output  4  operand b to operation blocks.
- alu_result  input  4  OR-combined block_out of all operation blocks.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester index that issued the command.
- rsp_data  output  4  captured result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; settle counter 0; last_grant=1, so req0 wins the first tie.
- Single clock domain. Outputs are registered except reqN_ready, which is combinational from state and valids.
- States: IDLE, DRIVE, RESP.
- IDLE arbitration:
  - Only req0_valid high -> grant 0. Only req1_valid high -> grant 1.
  - Both high -> grant the index != last_grant.
  - reqN_ready=1 only in IDLE, only for the granted requester. The ungranted ready is 0.
- Handshake (valid & ready) at edge T:
  - Latch op, a, b, id; update last_grant; go to DRIVE.
- DRIVE (cycles T+1 .. T+SETTLE_CYCLES):
  - op_enable = 1<<op; alu_a/alu_b = latched operands.
  - Counter increments each cycle.
  - On the last DRIVE cycle, register alu_result into rsp_data and rsp_id, set rsp_valid, go to RESP.
- Timing: op_enable deasserts and alu_a/alu_b return to 0 in the same cycle rsp_valid rises (T+SETTLE_CYCLES+1). Minimum request-to-response latency is SETTLE_CYCLES+1 cycles.
- RESP:
  - rsp_valid, rsp_data and rsp_id held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid clears, go to IDLE; the next grant is possible the following cycle.
  - No requester ready in DRIVE or RESP; one command is in flight at a time.
- Outside DRIVE: op_enable=0 and alu_a=alu_b=0, so the ALU output bus reads 0.
- ADD: rsp_data is the 4-bit sum only; carry is not sequenced by this block (wrap-around, e.g. 9+8 -> 1).
- Requester drops valid before grant: no command, no state change.
- Reset mid-operation: command abandoned, no response emitted; enables drop immediately with reset.
- rsp_ready high while rsp_valid low: ignored.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_STATS_EN.
- Defined:
  - Adds output op_count[7:0], incremented on each response handshake, wrapping 255->0, reset to 0.
  - Adds output conflict_count[7:0], incremented on each IDLE cycle where both valids are high and a grant occurs, wrapping, reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset mid-DRIVE: assert rst_n=0 -> op_enable, alu_a, alu_b, rsp_valid all 0 asynchronously; after release, req0 wins the first simultaneous request.
- Single AND, SETTLE_CYCLES=1: req0 op=0 a=4'hC b=4'hA, rsp_ready=1 -> op_enable=4'b0001 for exactly 1 cycle; rsp_valid 2 cycles after handshake; rsp_data=4'h8, rsp_id=0.
- ADD wrap: req1 op=3 a=9 b=8 -> op_enable=4'b1000; rsp_data=4'h1, rsp_id=1.
- Round-robin: both valids held high for 4 commands -> grants alternate 0,1,0,1; reqN_ready never high simultaneously.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, busy=1, both readies 0; rsp_ready=1 -> IDLE next cycle.
- SETTLE_CYCLES=3, op=2 a=5 b=3 -> op_enable=4'b0100 held exactly 3 cycles; rsp_data=4'h6.
